// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board geometry, idle write index and scheduler state encoding
package board_pkg;
  localparam int BOARD_ROWS = 20;
  localparam int ROW_W = 30;
  localparam logic [4:0] IDX_IDLE = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, pointer moves past the winner on each accepted grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);
  logic fav_b;

  always_comb begin
    gnt = 2'b00;
    if (fav_b) begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end else begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end

  // Favour whoever did not just win; an idle requester never holds the pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     fav_b <= 1'b0;
    else if (adv) fav_b <= gnt[0];
  end
endmodule

// File: rtl/board_write_sched.sv
// rtl/board_write_sched.sv - schedules piece/line-clear row writes and full-board wipes into blanking
module board_write_sched
  import board_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        blank,
  input  logic        a_valid,
  input  logic [4:0]  a_row,
  input  logic [29:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_row,
  input  logic [29:0] b_data,
  output logic        b_ready,
  input  logic        clr_req,
  output logic [4:0]  wr_index,
  output logic [29:0] wr_data,
  output logic        busy,
  output logic        row_err
);
  state_t            state;
  logic              clr_pend;
  logic [4:0]        row_cnt;
  logic [4:0]        wr_idx_q;
  logic [ROW_W-1:0]  wr_data_q;
  logic [1:0]        gnt;
  logic              open_slot;
  logic              xfer;
  logic [4:0]        sel_row;
  logic [ROW_W-1:0]  sel_data;
  logic              bad_row;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({b_valid, a_valid}),
    .adv (xfer),
    .gnt (gnt)
  );

  assign open_slot = rst && (state == ST_IDLE) && blank && !clr_pend;
  assign a_ready   = open_slot && gnt[0];
  assign b_ready   = open_slot && gnt[1];
  assign xfer      = (a_valid && a_ready) || (b_valid && b_ready);
  assign sel_row   = a_ready ? a_row  : b_row;
  assign sel_data  = a_ready ? a_data : b_data;
  assign bad_row   = sel_row >= 5'(BOARD_ROWS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wr_idx_q  <= IDX_IDLE;
      wr_data_q <= '0;
      row_err   <= 1'b0;
      clr_pend  <= 1'b0;
      row_cnt   <= 5'd0;
    end else begin
      row_err <= 1'b0;
      if (clr_req) clr_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            state     <= ST_WRITE;
            wr_idx_q  <= bad_row ? IDX_IDLE : sel_row;
            wr_data_q <= bad_row ? '0 : sel_data;
            row_err   <= bad_row;
          end else if (clr_pend && blank) begin
            state <= ST_CLEAR;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        ST_CLEAR: begin
          // The row counter only moves while blanking, so a wipe survives active video.
          if (blank) begin
            if (row_cnt == 5'(BOARD_ROWS - 1)) begin
              state    <= ST_IDLE;
              clr_pend <= 1'b0;
              row_cnt  <= 5'd0;
            end else begin
              row_cnt <= row_cnt + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_index = IDX_IDLE;
    wr_data  = '0;
    if (state == ST_WRITE) begin
      wr_index = wr_idx_q;
      wr_data  = wr_data_q;
    end else if (state == ST_CLEAR && blank) begin
      wr_index = row_cnt;
    end
  end

  assign busy = (state != ST_IDLE) || clr_pend;
endmodule

// File: tb/tb_board_write_sched.sv
// tb/tb_board_write_sched.sv - directed self-checking bench for board_write_sched
module tb_board_write_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        blank;
  logic        a_valid;
  logic [4:0]  a_row;
  logic [29:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_row;
  logic [29:0] b_data;
  logic        b_ready;
  logic        clr_req;
  logic [4:0]  wr_index;
  logic [29:0] wr_data;
  logic        busy;
  logic        row_err;

  int vecs = 0;
  int errs = 0;

  board_write_sched dut (
    .clk      (clk),
    .rst      (rst),
    .blank    (blank),
    .a_valid  (a_valid),
    .a_row    (a_row),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_row    (b_row),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .clr_req  (clr_req),
    .wr_index (wr_index),
    .wr_data  (wr_data),
    .busy     (busy),
    .row_err  (row_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; blank = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_row = 5'd3; b_row = 5'd4; clr_req = 1'b0;
    tick(); tick();
    #1;
    vecs++; if (a_ready !== 1'b0) begin errs++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
    vecs++; if (b_ready !== 1'b0) begin errs++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
    vecs++; if (wr_index !== 5'd31) begin errs++; $display("FAIL reset_wr_index: got %0d want 31", wr_index); end
    vecs++; if (wr_data !== 30'h0) begin errs++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (row_err !== 1'b0) begin errs++; $display("FAIL reset_row_err: got %b want 0", row_err); end
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_a_only;
    blank = 1'b1; a_valid = 1'b1; a_row = 5'd3; a_data = 30'h2AAAAAAA;
    #1;
    vecs++; if (a_ready !== 1'b1) begin errs++; $display("FAIL a_only_ready: got %b want 1", a_ready); end
    vecs++; if (b_ready !== 1'b0) begin errs++; $display("FAIL a_only_b_ready: got %b want 0", b_ready); end
    tick();
    a_valid = 1'b0;
    #1;
    vecs++; if (wr_index !== 5'd3) begin errs++; $display("FAIL a_only_idx_n1: got %0d want 3", wr_index); end
    vecs++; if (wr_data !== 30'h2AAAAAAA) begin errs++; $display("FAIL a_only_data_n1: got %h want 2aaaaaaa", wr_data); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL a_only_busy: got %b want 1", busy); end
    tick();
    #1;
    vecs++; if (wr_index !== 5'd31) begin errs++; $display("FAIL a_only_idx_n2: got %0d want 31", wr_index); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL a_only_idle: got %b want 0", busy); end
  endtask

  task automatic test_contention;
    int writes;
    logic ea, eb;
    logic [4:0] ei;
    do_reset();
    writes = 0;
    blank = 1'b1;
    a_valid = 1'b1; a_row = 5'd1; a_data = 30'h111;
    b_valid = 1'b1; b_row = 5'd2; b_data = 30'h222;
    for (int i = 0; i < 8; i++) begin
      #1;
      ea = (i % 4 == 0);
      eb = (i % 4 == 2);
      ei = (i % 4 == 1) ? 5'd1 : (i % 4 == 3) ? 5'd2 : 5'd31;
      vecs++; if (a_ready !== ea) begin errs++; $display("FAIL rr_a_ready cyc %0d: got %b want %b", i, a_ready, ea); end
      vecs++; if (b_ready !== eb) begin errs++; $display("FAIL rr_b_ready cyc %0d: got %b want %b", i, b_ready, eb); end
      vecs++; if (wr_index !== ei) begin errs++; $display("FAIL rr_wr_index cyc %0d: got %0d want %0d", i, wr_index, ei); end
      if (wr_index !== 5'd31) writes++;
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    vecs++; if (writes != 4) begin errs++; $display("FAIL rr_write_count: got %0d want 4", writes); end
    tick();
  endtask

  task automatic test_blank_gate;
    int bad;
    bad = 0;
    blank = 1'b0; a_valid = 1'b1; a_row = 5'd5; a_data = 30'h3FFF0001;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (a_ready !== 1'b0 || wr_index !== 5'd31) bad++;
      tick();
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL gate_hold: got %0d bad cycles want 0", bad); end
    blank = 1'b1;
    #1;
    vecs++; if (a_ready !== 1'b1) begin errs++; $display("FAIL gate_open: got %b want 1", a_ready); end
    tick();
    blank = 1'b0; a_valid = 1'b0;
    #1;
    vecs++; if (wr_index !== 5'd5) begin errs++; $display("FAIL gate_write_after_fall: got %0d want 5", wr_index); end
    vecs++; if (wr_data !== 30'h3FFF0001) begin errs++; $display("FAIL gate_data: got %h want 3fff0001", wr_data); end
    tick();
  endtask

  task automatic test_bad_row;
    blank = 1'b1; a_valid = 1'b0; b_valid = 1'b1; b_row = 5'd25; b_data = 30'h1234;
    #1;
    vecs++; if (b_ready !== 1'b1) begin errs++; $display("FAIL bad_row_ready: got %b want 1", b_ready); end
    tick();
    b_valid = 1'b0;
    #1;
    vecs++; if (row_err !== 1'b1) begin errs++; $display("FAIL bad_row_err: got %b want 1", row_err); end
    vecs++; if (wr_index !== 5'd31) begin errs++; $display("FAIL bad_row_idx: got %0d want 31", wr_index); end
    tick();
    #1;
    vecs++; if (row_err !== 1'b0) begin errs++; $display("FAIL bad_row_pulse: got %b want 0", row_err); end
  endtask

  task automatic test_clear_pause;
    int seen, bad;
    seen = 0; bad = 0;
    blank = 1'b0; a_valid = 1'b1; a_row = 5'd9; a_data = 30'h55;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL clr_pending_busy: got %b want 1", busy); end
    blank = 1'b1;
    for (int i = 0; i < 4 && seen == 0; i++) begin
      #1;
      if (a_ready !== 1'b0) bad++;
      if (wr_index === 5'd0) seen = 1; else tick();
    end
    vecs++; if (seen != 1) begin errs++; $display("FAIL clr_start: got no row 0 want row 0 within 4 cycles"); end
    for (int k = 0; k < 5; k++) begin
      if (wr_index !== 5'(k) || wr_data !== 30'h0 || a_ready !== 1'b0) bad++;
      tick(); #1;
    end
    blank = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (wr_index !== 5'd31 || a_ready !== 1'b0) bad++;
      tick();
    end
    blank = 1'b1;
    for (int k = 5; k < 20; k++) begin
      #1;
      if (wr_index !== 5'(k) || wr_data !== 30'h0 || a_ready !== 1'b0) bad++;
      tick();
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL clr_sequence: got %0d bad cycles want 0", bad); end
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL clr_done_busy: got %b want 0", busy); end
    vecs++; if (a_ready !== 1'b1) begin errs++; $display("FAIL clr_done_a_ready: got %b want 1", a_ready); end
    a_valid = 1'b0;
    tick();
  endtask

  task automatic test_clr_with_handshake;
    int rows, done;
    rows = 0; done = 0;
    blank = 1'b1; a_valid = 1'b1; a_row = 5'd2; a_data = 30'h777; clr_req = 1'b1;
    #1;
    vecs++; if (a_ready !== 1'b1) begin errs++; $display("FAIL clr_hs_ready: got %b want 1", a_ready); end
    tick();
    a_valid = 1'b0; clr_req = 1'b0;
    #1;
    vecs++; if (wr_index !== 5'd2) begin errs++; $display("FAIL clr_hs_write: got %0d want 2", wr_index); end
    for (int i = 0; i < 40 && done == 0; i++) begin
      tick(); #1;
      if (wr_index !== 5'd31) rows++;
      if (busy === 1'b0) done = 1;
    end
    vecs++; if (done != 1 || rows != 20) begin errs++; $display("FAIL clr_hs_clear: got done=%0d rows=%0d want done=1 rows=20", done, rows); end
  endtask

  task automatic test_reset_mid_clear;
    int seen, bad;
    seen = 0; bad = 0;
    blank = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      #1;
      if (wr_index === 5'd7) seen = 1; else tick();
    end
    vecs++; if (seen != 1) begin errs++; $display("FAIL rst_clr_reach7: got no row 7 want row 7 within 30 cycles"); end
    rst = 1'b0;
    #1;
    vecs++; if (wr_index !== 5'd31) begin errs++; $display("FAIL rst_clr_idx: got %0d want 31", wr_index); end
    tick();
    rst = 1'b1;
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_clr_busy: got %b want 0", busy); end
    for (int i = 0; i < 25; i++) begin
      tick(); #1;
      if (wr_index !== 5'd31 || busy !== 1'b0) bad++;
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL rst_clr_no_writes: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    rst = 1'b0; blank = 1'b0; clr_req = 1'b0;
    a_valid = 1'b0; a_row = 5'd0; a_data = 30'h0;
    b_valid = 1'b0; b_row = 5'd0; b_data = 30'h0;
    test_reset();
    test_a_only();
    test_contention();
    test_blank_gate();
    test_bad_row();
    test_clear_pause();
    test_clr_with_handshake();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/board_write_sched.md
BOARD_WRITE_SCHED -- requirements
Module: board_write_sched

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is rst, asynchronous, active-low.
REQ-003 SHALL have port blank, input, 1, high while the display is outside the active 640x480 region; board writes are permitted only then.
REQ-004 SHALL have ports a_valid (input, 1), a_row (input, 5), a_data (input, 30), a_ready (output, 1): requester A, piece placement.
REQ-005 SHALL have ports b_valid (input, 1), b_row (input, 5), b_data (input, 30), b_ready (output, 1): requester B, line-clear engine.
REQ-006 SHALL have port clr_req, input, 1, single-cycle pulse requesting a wipe of all 20 rows.
REQ-007 SHALL have ports wr_index (output, 5) and wr_data (output, 30), the board write port; index 5'b11111 means no write.
REQ-008 SHALL have ports busy (output, 1, high whenever the state is not IDLE or a clear is pending) and row_err (output, 1, single-cycle pulse).

Function
REQ-009 States SHALL be IDLE, WRITE and CLEAR.
REQ-010 A transfer on requester X SHALL occur in a cycle where x_valid and x_ready are both high.
REQ-011 x_ready SHALL be combinational and high only when all of the following hold: state IDLE, blank high, no clear pending, and requester X wins arbitration.
REQ-012 Arbitration SHALL be round-robin between A and B.
REQ-013 The pointer SHALL toggle to favour the other requester after each transfer, and SHALL be unchanged when there is no transfer.
REQ-014 A requester whose valid is low SHALL never block the other.
REQ-015 At most one of a_ready and b_ready SHALL be high in any cycle.
REQ-016 A transfer at cycle N SHALL drive the accepted row and data on wr_index and wr_data at cycle N+1 for exactly one cycle (state WRITE), then return to IDLE at N+2.
REQ-017 Throughput SHALL therefore be at most one row write per 2 cycles.
REQ-018 If the accepted row is greater than 19, the block SHALL still complete the transfer, but SHALL keep wr_index at 5'b11111 and pulse row_err at N+1.
REQ-019 clr_req SHALL set a clear-pending flag, and further pulses while the flag is set SHALL be absorbed.
REQ-020 A pending clear SHALL take priority over both requesters.
REQ-021 A pending clear SHALL enter CLEAR from IDLE on the first cycle in which blank is high.
REQ-022 In CLEAR, the block SHALL drive rows 0,1,...,19 with wr_data 30'b0, one row per cycle while blank is high.
REQ-023 In CLEAR, wr_index SHALL be 5'b11111 while blank is low, and the row counter SHALL hold and resume at the next blank.
REQ-024 After row 19 is written, the block SHALL clear the pending flag, reset the row counter to 0 and return to IDLE.
REQ-025 While not in WRITE or CLEAR, or while paused, wr_index SHALL be 5'b11111 and wr_data SHALL be 30'b0.
REQ-026 A clr_req arriving in the same cycle as a requester handshake SHALL let that transfer complete, with CLEAR following afterwards.
REQ-027 If blank falls in the same cycle as a transfer, the block SHALL still issue the WRITE at N+1.

Reset
REQ-028 On rst low, the block SHALL asynchronously set: state IDLE, wr_index 5'b11111, wr_data 0, row_err 0, busy 0, clear-pending 0, row counter 0, round-robin pointer favouring A.
REQ-029 Both ready outputs SHALL be 0 during reset.
REQ-030 A reset asserted mid-CLEAR or mid-WRITE SHALL abandon the operation, with no write after release.

Structure
REQ-031 A shared package board_pkg SHALL hold BOARD_ROWS=20, ROW_W=30, IDX_IDLE=5'b11111, and the state enum.
REQ-032 The round-robin decision SHALL be a sub-module rr_arb2, with inputs clk, rst, req[1:0], adv and output gnt[1:0] (one-hot or zero).

Verification
REQ-033 A-only write: blank=1, a_valid with row 3, data 30'h2AAAAAAA -> a_ready=1 at N; wr_index=3 and wr_data=30'h2AAAAAAA at N+1; wr_index=31 at N+2.
REQ-034 Contention: A and B both valid continuously, blank=1 -> grants alternate A,B,A,B starting with A after reset; 4 writes in 8 cycles.
REQ-035 Blanking gate: blank=0, a_valid=1 for 10 cycles -> a_ready=0 and wr_index=31 throughout; blank rises -> transfer in that cycle.
REQ-036 Clear with pause: clr_req pulse, then blank high for 5 cycles, low for 3, then high -> rows 0..4, a gap of 3 cycles, rows 5..19, then busy=0; requester A held off until done.
REQ-037 Bad row: b_row=25 accepted -> row_err pulse at N+1, wr_index=31.
REQ-038 Reset mid-clear: rst low during row 7 -> wr_index=31; after release busy=0 and no further clear writes.
